// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding and default game parameters,
// used by score_keeper and target_gen.
package game_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PLAYING   = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;

  localparam int SHOTS_PER_GAME_D  = 8;
  localparam int SCORE_W_D         = 5;
  localparam int STREAK_BONUS_AT_D = 3;

  // Streak counter is 3 bits and sticks at 7 instead of wrapping.
  function automatic logic [2:0] streak_inc(input logic [2:0] s);
    return (s == 3'd7) ? 3'd7 : s + 3'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector: pulse is high for the one cycle where d
// is high and was low on the previous clock.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/score_keeper.sv
// Game round controller: counts shots from trajectory_calc, scores hits with
// a streak bonus, tracks the session high score and flags game over.
//
// Handshake: result_valid and start_new_game are level signals; only their
// rising edges act, a held level counts once, and hit is sampled on the same
// clock as the result_valid rising edge. There is no back-pressure.
module score_keeper
  import game_pkg::*;
#(
  parameter int SHOTS_PER_GAME  = SHOTS_PER_GAME_D,
  parameter int SCORE_W         = SCORE_W_D,
  parameter int STREAK_BONUS_AT = STREAK_BONUS_AT_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               start_new_game,
  input  logic               result_valid,
  input  logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [3:0]         shots_left,
  output logic [2:0]         streak,
  output logic               in_play,
  output logic               game_over,
  output logic               score_event,
  output logic [1:0]         state_dbg
);

  localparam logic [3:0] SHOTS_INIT = 4'(SHOTS_PER_GAME);

  logic start_e, res_e;

  // Detector flops run regardless of ena so enabling never creates an edge.
  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start_new_game),
    .pulse (start_e)
  );

  rise_detect u_result_rise (
    .clk   (clk),
    .reset (reset),
    .d     (result_valid),
    .pulse (res_e)
  );

  logic [1:0]         state, state_n;
  logic [SCORE_W-1:0] score_n, high_n, final_score;
  logic [3:0]         shots_n;
  logic [2:0]         streak_n;
  logic               score_event_n;

  // Saturating hit score: +1, or +2 once the new streak reaches the bonus level.
  logic [2:0]         streak_hit;
  logic [1:0]         bonus_inc;
  logic [SCORE_W:0]   inc_ext, score_sum;
  logic [SCORE_W-1:0] score_hit;

  assign streak_hit = streak_inc(streak);
  assign bonus_inc  = (int'(streak_hit) >= STREAK_BONUS_AT) ? 2'd2 : 2'd1;
  assign inc_ext    = {{(SCORE_W-1){1'b0}}, bonus_inc};
  assign score_sum  = {1'b0, score} + inc_ext;
  assign score_hit  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_comb begin
    state_n       = state;
    score_n       = score;
    high_n        = high_score;
    shots_n       = shots_left;
    streak_n      = streak;
    score_event_n = 1'b0;
    final_score   = score;
    if (ena) begin
      if (start_e) begin
        // A start edge always wins, including over a coincident result edge.
        state_n  = PLAYING;
        score_n  = '0;
        streak_n = 3'd0;
        shots_n  = SHOTS_INIT;
      end else if (res_e && state == PLAYING && shots_left != 4'd0) begin
        shots_n = shots_left - 4'd1;
        if (hit) begin
          streak_n      = streak_hit;
          score_n       = score_hit;
          final_score   = score_hit;
          score_event_n = 1'b1;
        end else begin
          streak_n = 3'd0;
        end
        if (shots_left == 4'd1) begin
          state_n = GAME_OVER;
          if (final_score > high_score) high_n = final_score;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      score       <= '0;
      high_score  <= '0;
      shots_left  <= SHOTS_INIT;
      streak      <= 3'd0;
      in_play     <= 1'b0;
      game_over   <= 1'b0;
      score_event <= 1'b0;
    end else begin
      state       <= state_n;
      score       <= score_n;
      high_score  <= high_n;
      shots_left  <= shots_n;
      streak      <= streak_n;
      in_play     <= (state_n == PLAYING);
      game_over   <= (state_n == GAME_OVER);
      score_event <= score_event_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a game-rule model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       start_new_game = 1'b0;
  logic       result_valid = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] score, high_score;
  logic [3:0] shots_left;
  logic [2:0] streak;
  logic       in_play, game_over, score_event;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int ev_cnt = 0;

  score_keeper dut (
    .clk            (clk),
    .reset          (rst),
    .ena            (ena),
    .start_new_game (start_new_game),
    .result_valid   (result_valid),
    .hit            (hit),
    .score          (score),
    .high_score     (high_score),
    .shots_left     (shots_left),
    .streak         (streak),
    .in_play        (in_play),
    .game_over      (game_over),
    .score_event    (score_event),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- game model ----------------
  // phase: 0 = waiting, 1 = playing, 2 = over
  int m_phase, m_score, m_high, m_shots, m_streak;
  bit m_ev, m_prev_start, m_prev_rv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_score = 0; m_high = 0; m_shots = 8; m_streak = 0;
      m_ev = 0; m_prev_start = 0; m_prev_rv = 0;
    end else begin
      bit new_start, new_result;
      new_start    = start_new_game && !m_prev_start;
      new_result   = result_valid && !m_prev_rv;
      m_prev_start = start_new_game;
      m_prev_rv    = result_valid;
      m_ev = 0;
      if (ena) begin
        if (new_start) begin
          m_phase = 1; m_score = 0; m_streak = 0; m_shots = 8;
        end else if (new_result && m_phase == 1) begin
          m_shots = m_shots - 1;
          if (hit) begin
            m_streak = (m_streak + 1 > 7) ? 7 : m_streak + 1;
            m_score  = m_score + 1 + ((m_streak >= 3) ? 1 : 0);
            if (m_score > 31) m_score = 31;
            m_ev = 1;
          end else begin
            m_streak = 0;
          end
          if (m_shots == 0) begin
            m_phase = 2;
            if (m_score > m_high) m_high = m_score;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("score",       int'(score),       m_score);
    check("high_score",  int'(high_score),  m_high);
    check("shots_left",  int'(shots_left),  m_shots);
    check("streak",      int'(streak),      m_streak);
    check("in_play",     int'(in_play),     (m_phase == 1) ? 1 : 0);
    check("game_over",   int'(game_over),   (m_phase == 2) ? 1 : 0);
    check("score_event", int'(score_event), int'(m_ev));
    if (score_event) ev_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start_game();
    start_new_game = 1'b1;
    cyc();
    start_new_game = 1'b0;
    cyc();
  endtask

  task automatic shot(input bit h);
    result_valid = 1'b1;
    hit = h;
    cyc();
    result_valid = 1'b0;
    hit = 1'b0;
    cyc();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ev_base;
    bit pat_a [8] = '{1, 1, 1, 0, 1, 0, 1, 0};
    bit pat_b [8] = '{1, 0, 1, 0, 0, 0, 0, 0};

    // 1: reset and first start
    rst = 1'b1;
    cyc(); cyc();
    check("lit_reset_score", int'(score), 0);
    check("lit_reset_shots", int'(shots_left), 8);
    check("lit_reset_in_play", int'(in_play), 0);
    check("lit_reset_game_over", int'(game_over), 0);
    rst = 1'b0;
    cyc();
    start_new_game = 1'b1;
    cyc();
    check("lit_start_in_play", int'(in_play), 1);
    start_new_game = 1'b0;
    cyc();

    // 2: three hits with bonus, then a miss
    ev_base = ev_cnt;
    shot(1); check("lit_hit1_score", int'(score), 1); check("lit_hit1_streak", int'(streak), 1);
    shot(1); check("lit_hit2_score", int'(score), 2); check("lit_hit2_streak", int'(streak), 2);
    shot(1); check("lit_hit3_score", int'(score), 4); check("lit_hit3_streak", int'(streak), 3);
    check("lit_event_count", ev_cnt - ev_base, 3);
    shot(0);
    check("lit_miss_streak", int'(streak), 0);
    check("lit_miss_score", int'(score), 4);

    // 3: held result_valid counts once
    start_game();
    result_valid = 1'b1; hit = 1'b1;
    repeat (5) cyc();
    result_valid = 1'b0; hit = 1'b0;
    cyc();
    check("lit_held_shots", int'(shots_left), 7);
    check("lit_held_score", int'(score), 1);

    // 4: full game to 6, then a game to 2
    start_game();
    for (int i = 0; i < 8; i++) shot(pat_a[i]);
    check("lit_g1_game_over", int'(game_over), 1);
    check("lit_g1_high", int'(high_score), 6);
    check("lit_g1_score", int'(score), 6);
    shot(1);
    check("lit_over_ignores_shot", int'(score), 6);
    start_game();
    for (int i = 0; i < 8; i++) shot(pat_b[i]);
    check("lit_g2_score", int'(score), 2);
    check("lit_g2_high", int'(high_score), 6);

    // 5: start and result on the same edge while playing
    start_game();
    shot(1);
    start_new_game = 1'b1; result_valid = 1'b1; hit = 1'b1;
    cyc();
    check("lit_coinc_shots", int'(shots_left), 8);
    check("lit_coinc_score", int'(score), 0);
    check("lit_coinc_event", int'(score_event), 0);
    start_new_game = 1'b0; result_valid = 1'b0; hit = 1'b0;
    cyc();

    // 6: edge arriving while disabled is lost
    ena = 1'b0;
    result_valid = 1'b1; hit = 1'b1;
    cyc(); cyc();
    ena = 1'b1;
    cyc(); cyc();
    result_valid = 1'b0; hit = 1'b0;
    cyc();
    check("lit_ena_shots", int'(shots_left), 8);
    check("lit_ena_score", int'(score), 0);

    // reset mid-game acts immediately
    shot(1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("lit_midrst_in_play", int'(in_play), 0);
    check("lit_midrst_high", int'(high_score), 0);
    check("lit_midrst_score", int'(score), 0);
    check("lit_midrst_state", int'(state_dbg), 0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
